snn_input_current_scheduler: RTL
================================

Name: snn_input_current_scheduler

Overview:
- Time-multiplexes one shared input-current calculator (registered on its enable; result valid the cycle after enable) across N_NEURONS neurons of an SNN layer, once per timestep.
- Per timestep, captures the layer's input spike vector on start.
- For each neuron in ascending index order:
  - fetches that neuron's weight row from a synchronous weight memory,
  - pulses the calculator enable,
  - then strobes that neuron's membrane update while the computed current is valid.
- Sits between the timestep controller and the calculator/neuron array.

Parameters:
N_NEURONS, 4, number of neurons sharing the calculator (>=1)
M, 4, input spikes per neuron (calculator fan-in)
WBITS, 2, bits per weight
IDXW, derived = max(1, clog2(N_NEURONS)), neuron index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active high
start  in  1  begin a timestep; sampled only in IDLE
input_spikes  in  M  layer input spikes for this timestep
weight_rd_en  out  1  weight memory read strobe
weight_addr  out  IDXW  weight row address (= neuron index)
weight_rdata  in  M*WBITS  weight row; valid the cycle after weight_rd_en
calc_enable  out  1  enable to shared current calculator
calc_spikes  out  M  spikes presented to calculator (captured copy)
calc_weights  out  M*WBITS  weights presented to calculator
neuron_update_en  out  N_NEURONS  one-hot update strobe; calculator output valid
update_idx  out  IDXW  index of neuron being updated
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of timestep

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Async reset: state=IDLE, idx=0, spike_reg=0.
  - All outputs at reset: weight_rd_en=0, weight_addr=0, calc_enable=0, calc_spikes=0, calc_weights=0, neuron_update_en=0, update_idx=0, busy=0, done=0.
- FSM states: IDLE, FETCH, CALC, UPDATE, DONE. Outputs decoded from state/idx (Moore).
  - calc_weights is the exception: a combinational pass-through of weight_rdata during CALC, 0 otherwise.
- IDLE:
  - If start=1: spike_reg<=input_spikes, idx<=0, go to FETCH.
  - Else stay.
- FETCH: weight_rd_en=1, weight_addr=idx. Go to CALC.
- CALC: calc_enable=1, calc_weights=weight_rdata. Go to UPDATE.
- UPDATE:
  - neuron_update_en[idx]=1 (all other bits 0), update_idx=idx.
  - If idx==N_NEURONS-1, go to DONE; else idx<=idx+1 and go to FETCH.
- DONE: done=1. Go to IDLE.
- calc_spikes = spike_reg whenever busy, 0 in IDLE. input_spikes changes after the start cycle have no effect.
- weight_addr = idx in FETCH, 0 otherwise.
- Latency:
  - Start sampled at cycle 0 → neuron k sees FETCH at 1+3k, CALC at 2+3k, UPDATE at 3+3k.
  - done at cycle 3*N_NEURONS+1.
  - Earliest next start is sampled at cycle 3*N_NEURONS+2.
- start while busy (including the DONE cycle): ignored. No queuing, no effect on the sequence.
- start held high continuously: a new timestep begins every 3*N_NEURONS+2 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs 0, and no done pulse. The next start restarts at neuron 0.
- N_NEURONS=1: idx stays 0, and the sequence is FETCH, CALC, UPDATE, DONE.
- No arithmetic beyond the idx increment. idx never exceeds N_NEURONS-1 (no wrap beyond the last neuron).

Test Plan:
- N_NEURONS=4, start pulse at cycle 0:
  - weight_rd_en with weight_addr 0,1,2,3 at cycles 1,4,7,10.
  - calc_enable at 2,5,8,11.
  - neuron_update_en 0001,0010,0100,1000 at 3,6,9,12.
  - done=1 at cycle 13 only; busy high for cycles 1-13.
- Spike capture: input_spikes=1010 at the start cycle, then 0101 from cycle 1 → calc_spikes=1010 in every busy cycle; calc_spikes=0 in IDLE.
- Weight pass-through: memory model returns row k = {k,k,k,k} one cycle after its address → calc_weights equals row k exactly in CALC cycle 2+3k, and 0 in all other cycles.
- Start pulses at cycles 5 and 13 while busy → sequence identical to the first scenario, with no second timestep. A start at cycle 14 → FETCH of neuron 0 at cycle 15.
- Reset asserted at cycle 6 for one cycle → all outputs 0 from the reset edge, no done pulse. A following start runs the full 14-cycle sequence from idx 0.
- N_NEURONS=1 build, start at cycle 0 → FETCH at 1, CALC at 2, neuron_update_en=1 at 3, done at 4.

Source files
------------

// File: rtl/snn_input_current_scheduler.sv
// snn_input_current_scheduler
// Shares one input-current calculator across the neurons of an SNN layer.
// On start it captures the layer input spikes. It then walks the neurons in
// ascending order. For each neuron it fetches the weight row, enables the
// calculator, and strobes that neuron's membrane update. Outputs are decoded
// from the state register and the neuron index. The one exception is
// calc_weights, which passes the weight memory read data straight through
// during CALC.
module snn_input_current_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int M         = 4,
    parameter int WBITS     = 2,
    localparam int IDXW     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [M-1:0]          input_spikes,
    output logic                  weight_rd_en,
    output logic [IDXW-1:0]       weight_addr,
    input  logic [M*WBITS-1:0]    weight_rdata,
    output logic                  calc_enable,
    output logic [M-1:0]          calc_spikes,
    output logic [M*WBITS-1:0]    calc_weights,
    output logic [N_NEURONS-1:0]  neuron_update_en,
    output logic [IDXW-1:0]       update_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_CALC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [M-1:0]    spike_q, spike_d;

    // State, neuron index and captured spike vector registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDXW{1'b0}};
            spike_q <= {M{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            spike_q <= spike_d;
        end
    end

    // Next-state logic: one FETCH/CALC/UPDATE triple per neuron, then DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        spike_d = spike_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    spike_d = input_spikes;
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // The index stops at the last neuron and never wraps.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDXW{1'b0}};
            end
        endcase
    end

    // Moore output decode from state and index; calc_weights is the pass-through.
    always_comb begin
        weight_rd_en     = 1'b0;
        weight_addr      = {IDXW{1'b0}};
        calc_enable      = 1'b0;
        calc_weights     = {(M*WBITS){1'b0}};
        neuron_update_en = {N_NEURONS{1'b0}};
        update_idx       = {IDXW{1'b0}};
        done             = 1'b0;
        busy             = (state_q != ST_IDLE);
        calc_spikes      = busy ? spike_q : {M{1'b0}};
        case (state_q)
            ST_FETCH: begin
                weight_rd_en = 1'b1;
                weight_addr  = idx_q;
            end
            ST_CALC: begin
                calc_enable  = 1'b1;
                calc_weights = weight_rdata;
            end
            ST_UPDATE: begin
                update_idx = idx_q;
                for (int n = 0; n < N_NEURONS; n++) begin
                    neuron_update_en[n] = (idx_q == IDXW'(n));
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule
